// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared symbol types and constants for the JPEG entropy front end
package jpeg_pkg;

  localparam int COEF_W    = 11;
  localparam int BLOCK_LEN = 64;
  localparam logic [3:0] ZRL_RUN = 4'd15;

  typedef struct packed {
    logic              is_dc;
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
    logic              last;
  } rle_sym_t;

  localparam rle_sym_t EOB_SYM = rle_sym_t'{1'b0, 4'd0, 4'd0, {COEF_W{1'b0}}, 1'b1};
  localparam rle_sym_t ZRL_SYM = rle_sym_t'{1'b0, ZRL_RUN, 4'd0, {COEF_W{1'b0}}, 1'b0};

  typedef enum logic {RUN, ZRL} rle_state_t;

endpackage

// File: rtl/rle_magnitude.sv
// rtl/rle_magnitude.sv - signed value to JPEG (size, amplitude) category
module rle_magnitude #(
  parameter int W  = 12,
  parameter int AW = 11
) (
  input  logic signed [W-1:0]  value,
  output logic        [3:0]    size,
  output logic        [AW-1:0] amp
);

  logic [W-1:0] mag;
  logic [W-1:0] vm1;
  logic [W-1:0] mask;

  always_comb begin
    mag  = value[W-1] ? W'(-value) : W'(value);
    size = 4'd0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    // negative values use the one's-complement form of |v| in size bits
    vm1  = W'(value - W'(1));
    mask = ~({W{1'b1}} << size);
    amp  = value[W-1] ? AW'(vm1 & mask) : AW'(value);
  end

endmodule

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - run-length/size encoder for one zigzag-ordered 8x8 coefficient stream
module rle_encoder #(
  parameter int DATA_WIDTH = jpeg_pkg::COEF_W,
  parameter int BLOCK_LEN  = jpeg_pkg::BLOCK_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dc_clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_dc,
  output logic [3:0]                   out_run,
  output logic [3:0]                   out_size,
  output logic [DATA_WIDTH-1:0]        out_amp,
  output logic                         out_last
);
  import jpeg_pkg::*;

  localparam int IDX_W = $clog2(BLOCK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  rle_state_t state, state_nx;
  logic [IDX_W-1:0]              idx;
  logic [3:0]                    run;
  logic [1:0]                    pend_zrl;
  logic [1:0]                    zrl_left;
  logic signed [DATA_WIDTH-1:0]  pred;
  rle_sym_t                      out_sym;
  rle_sym_t                      held_sym;
  rle_sym_t                      coef_sym;
  logic                          out_valid_q;

  logic                          in_fire, out_fire;
  logic                          is_dc_idx, coef_zero;
  logic signed [DATA_WIDTH:0]    coef_ext, pred_ext, mag_in;
  logic [3:0]                    mag_size;
  logic [DATA_WIDTH-1:0]         mag_amp;

  assign in_ready  = rst_n & (state == RUN) & (!out_valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign is_dc_idx = (idx == '0);
  assign coef_zero = (in_data == '0);

  // dc_clear in the DC cycle restarts prediction from zero for this very diff
  assign coef_ext = {in_data[DATA_WIDTH-1], in_data};
  assign pred_ext = dc_clear ? '0 : {pred[DATA_WIDTH-1], pred};
  assign mag_in   = is_dc_idx ? (coef_ext - pred_ext) : coef_ext;

  rle_magnitude #(.W(DATA_WIDTH + 1), .AW(DATA_WIDTH)) u_mag (
    .value (mag_in),
    .size  (mag_size),
    .amp   (mag_amp)
  );

  always_comb begin
    coef_sym       = '0;
    coef_sym.is_dc = is_dc_idx;
    coef_sym.run   = is_dc_idx ? 4'd0 : run;
    coef_sym.size  = mag_size;
    coef_sym.amp   = mag_amp;
    coef_sym.last  = !is_dc_idx && (idx == LAST_IDX);
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN: if (in_fire && !is_dc_idx && !coef_zero && pend_zrl != 2'd0) state_nx = ZRL;
      ZRL: if (out_fire && zrl_left == 2'd0) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      run         <= '0;
      pend_zrl    <= '0;
      zrl_left    <= '0;
      pred        <= '0;
      out_sym     <= '0;
      held_sym    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_fire) out_valid_q <= 1'b0;
      if (dc_clear) pred <= '0;
      if (in_fire) begin
        idx <= idx + 1'b1;
        if (is_dc_idx) begin
          pred        <= in_data;
          out_sym     <= coef_sym;
          out_valid_q <= 1'b1;
        end else if (coef_zero) begin
          if (idx == LAST_IDX) begin
            out_sym     <= EOB_SYM;
            out_valid_q <= 1'b1;
            run         <= '0;
            pend_zrl    <= '0;
          end else if (run == ZRL_RUN) begin
            run      <= '0;
            pend_zrl <= pend_zrl + 2'd1;
          end else begin
            run <= run + 4'd1;
          end
        end else begin
          run         <= '0;
          pend_zrl    <= '0;
          out_valid_q <= 1'b1;
          if (pend_zrl == 2'd0) begin
            out_sym <= coef_sym;
          end else begin
            out_sym  <= ZRL_SYM;
            held_sym <= coef_sym;
            zrl_left <= pend_zrl - 2'd1;
          end
        end
      end else if (state == ZRL && out_fire) begin
        // the first ZRL went out with the coefficient; drain the rest, then the held symbol
        out_valid_q <= 1'b1;
        if (zrl_left == 2'd0) begin
          out_sym <= held_sym;
        end else begin
          out_sym  <= ZRL_SYM;
          zrl_left <= zrl_left - 2'd1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_is_dc = out_sym.is_dc;
  assign out_run   = out_sym.run;
  assign out_size  = out_sym.size;
  assign out_amp   = out_sym.amp;
  assign out_last  = out_sym.last;

endmodule
